// File: rtl/morse_pkg.sv
// Shared constants for the Morse player family: segment glyphs, symbol codes,
// state encoding and segment lengths in Morse time units.
package morse_pkg;

  // Active-low 7-segment glyphs, bit order gfedcba.
  localparam logic [6:0] SEG_DOT  = 7'b0100011;
  localparam logic [6:0] SEG_DASH = 7'b1110111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_E    = 7'b0000110;
  localparam logic [6:0] SEG_R    = 7'b0101111;

  localparam int CODE_WORD      = 36;
  localparam int CODE_MAX_VALID = 35;

  localparam int DOT_UNITS  = 1;
  localparam int DASH_UNITS = 3;
  localparam int GAP_UNITS  = 1;
  localparam int LGAP_UNITS = 3;
  localparam int WORD_UNITS = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_GAP,
    S_LGAP,
    S_WORD,
    S_ERROR
  } state_t;

  function automatic logic [6:0] elem_glyph(input logic dash);
    return dash ? SEG_DASH : SEG_DOT;
  endfunction

  function automatic logic [2:0] mark_units(input logic dash);
    return dash ? 3'(DASH_UNITS) : 3'(DOT_UNITS);
  endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational ITU Morse lookup: code -> element count and MSB-first pattern
// (1 = dash). Codes above 35 (including the word space) report invalid.
module morse_rom
  import morse_pkg::*;
#(
  parameter int CODE_WIDTH = 6
) (
  input  logic [CODE_WIDTH-1:0] code,
  output logic [2:0]            len,
  output logic [4:0]            pattern,
  output logic                  invalid
);

  always_comb begin
    len     = 3'd0;
    pattern = 5'b00000;
    invalid = 1'b1;
    if (code <= CODE_WIDTH'(CODE_MAX_VALID)) begin
      invalid = 1'b0;
      case (code[5:0])
        6'd0:  {len, pattern} = {3'd5, 5'b11111};
        6'd1:  {len, pattern} = {3'd5, 5'b01111};
        6'd2:  {len, pattern} = {3'd5, 5'b00111};
        6'd3:  {len, pattern} = {3'd5, 5'b00011};
        6'd4:  {len, pattern} = {3'd5, 5'b00001};
        6'd5:  {len, pattern} = {3'd5, 5'b00000};
        6'd6:  {len, pattern} = {3'd5, 5'b10000};
        6'd7:  {len, pattern} = {3'd5, 5'b11000};
        6'd8:  {len, pattern} = {3'd5, 5'b11100};
        6'd9:  {len, pattern} = {3'd5, 5'b11110};
        6'd10: {len, pattern} = {3'd2, 5'b01000};
        6'd11: {len, pattern} = {3'd4, 5'b10000};
        6'd12: {len, pattern} = {3'd4, 5'b10100};
        6'd13: {len, pattern} = {3'd3, 5'b10000};
        6'd14: {len, pattern} = {3'd1, 5'b00000};
        6'd15: {len, pattern} = {3'd4, 5'b00100};
        6'd16: {len, pattern} = {3'd3, 5'b11000};
        6'd17: {len, pattern} = {3'd4, 5'b00000};
        6'd18: {len, pattern} = {3'd2, 5'b00000};
        6'd19: {len, pattern} = {3'd4, 5'b01110};
        6'd20: {len, pattern} = {3'd3, 5'b10100};
        6'd21: {len, pattern} = {3'd4, 5'b01000};
        6'd22: {len, pattern} = {3'd2, 5'b11000};
        6'd23: {len, pattern} = {3'd2, 5'b10000};
        6'd24: {len, pattern} = {3'd3, 5'b11100};
        6'd25: {len, pattern} = {3'd4, 5'b01100};
        6'd26: {len, pattern} = {3'd4, 5'b11010};
        6'd27: {len, pattern} = {3'd3, 5'b01000};
        6'd28: {len, pattern} = {3'd3, 5'b00000};
        6'd29: {len, pattern} = {3'd1, 5'b10000};
        6'd30: {len, pattern} = {3'd3, 5'b00100};
        6'd31: {len, pattern} = {3'd4, 5'b00010};
        6'd32: {len, pattern} = {3'd3, 5'b01100};
        6'd33: {len, pattern} = {3'd4, 5'b10010};
        6'd34: {len, pattern} = {3'd4, 5'b10110};
        6'd35: {len, pattern} = {3'd4, 5'b11000};
        default: {len, pattern} = {3'd0, 5'b00000};
      endcase
    end
  end

endmodule

// File: rtl/morse_player.sv
// Accepts one symbol code over valid/ready and plays it as a timed Morse key
// waveform, revealing each element on the HEX digits as its mark starts.
module morse_player
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12500000,
  parameter int NUM_DIGITS  = 5,
  parameter int CODE_WIDTH  = 6
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [CODE_WIDTH-1:0]   code,
  input  logic                    code_valid,
  output logic                    code_ready,
  output logic                    key_out,
  output logic                    busy,
  output logic                    code_error,
  output logic [7*NUM_DIGITS-1:0] hex
);

  localparam int CNT_W = $clog2(UNIT_CYCLES);

  state_t                         state;
  logic [CNT_W-1:0]               unit_cnt;
  logic [2:0]                     seg_units;
  logic [2:0]                     seg_len;
  logic [2:0]                     elem_idx;
  logic [2:0]                     len_q;
  logic [4:0]                     pat_q;
  logic [NUM_DIGITS-1:0][6:0]     digits;

  logic [2:0] rom_len;
  logic [4:0] rom_pattern;
  logic       rom_invalid;
  logic       tick;
  logic       seg_done;

  morse_rom #(.CODE_WIDTH(CODE_WIDTH)) u_rom (
    .code    (code),
    .len     (rom_len),
    .pattern (rom_pattern),
    .invalid (rom_invalid)
  );

  assign tick     = (unit_cnt == CNT_W'(UNIT_CYCLES - 1));
  assign seg_done = tick && (seg_units == seg_len - 3'd1);
  assign hex      = digits;

  // pat_q is kept left-aligned so bit 4 is always the element being played.
  // NOTE: every register here is updated with <= so all branches see the
  // pre-edge values of state, counters and pattern within the same clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      unit_cnt   <= '0;
      seg_units  <= 3'd0;
      seg_len    <= 3'd1;
      elem_idx   <= 3'd0;
      len_q      <= 3'd0;
      pat_q      <= 5'd0;
      digits     <= {NUM_DIGITS{SEG_OFF}};
      code_ready <= 1'b1;
      key_out    <= 1'b0;
      busy       <= 1'b0;
      code_error <= 1'b0;
    end else begin
      code_error <= 1'b0;
      if (state != S_IDLE) begin
        unit_cnt <= tick ? '0 : unit_cnt + 1'b1;
        if (tick) seg_units <= seg_done ? 3'd0 : seg_units + 3'd1;
      end

      case (state)
        S_IDLE: begin
          if (code_valid && code_ready) begin
            unit_cnt   <= '0;
            seg_units  <= 3'd0;
            code_ready <= 1'b0;
            busy       <= 1'b1;
            if (!rom_invalid) begin
              state                  <= S_MARK;
              pat_q                  <= rom_pattern;
              len_q                  <= rom_len;
              elem_idx               <= 3'd0;
              seg_len                <= mark_units(rom_pattern[4]);
              key_out                <= 1'b1;
              digits                 <= {NUM_DIGITS{SEG_OFF}};
              digits[NUM_DIGITS-1]   <= elem_glyph(rom_pattern[4]);
            end else if (code == CODE_WIDTH'(CODE_WORD)) begin
              state   <= S_WORD;
              seg_len <= 3'(WORD_UNITS);
              digits  <= {NUM_DIGITS{SEG_OFF}};
            end else begin
              state                <= S_ERROR;
              code_error           <= 1'b1;
              digits               <= {NUM_DIGITS{SEG_OFF}};
              digits[NUM_DIGITS-1] <= SEG_E;
              digits[NUM_DIGITS-2] <= SEG_R;
              digits[NUM_DIGITS-3] <= SEG_R;
              digits[NUM_DIGITS-4] <= SEG_DOT;
              digits[NUM_DIGITS-5] <= SEG_R;
            end
          end
        end

        S_MARK: begin
          if (seg_done) begin
            key_out <= 1'b0;
            if (elem_idx == len_q - 3'd1) begin
              state   <= S_LGAP;
              seg_len <= 3'(LGAP_UNITS);
            end else begin
              state   <= S_GAP;
              seg_len <= 3'(GAP_UNITS);
            end
          end
        end

        S_GAP: begin
          if (seg_done) begin
            state    <= S_MARK;
            key_out  <= 1'b1;
            elem_idx <= elem_idx + 3'd1;
            pat_q    <= pat_q << 1;
            seg_len  <= mark_units(pat_q[3]);
            for (int k = 1; k < 5; k++) begin
              if (3'(k) == elem_idx + 3'd1) digits[NUM_DIGITS-1-k] <= elem_glyph(pat_q[3]);
            end
          end
        end

        S_LGAP, S_WORD: begin
          if (seg_done) begin
            state      <= S_IDLE;
            code_ready <= 1'b1;
            busy       <= 1'b0;
          end
        end

        S_ERROR: begin
          state      <= S_IDLE;
          code_ready <= 1'b1;
          busy       <= 1'b0;
        end

        default: begin
          state      <= S_IDLE;
          code_ready <= 1'b1;
          busy       <= 1'b0;
          key_out    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_player.sv
// Randomised and directed bench for morse_player; expected waveforms come from
// a dot/dash string table and the unit-timing rules.
module tb_morse_player;

  localparam int U  = 4;
  localparam int ND = 6;
  localparam int CW = 6;

  localparam logic [6:0] G_DOT  = 7'b0100011;
  localparam logic [6:0] G_DASH = 7'b1110111;
  localparam logic [6:0] G_OFF  = 7'h7F;
  localparam logic [6:0] G_E    = 7'b0000110;
  localparam logic [6:0] G_R    = 7'b0101111;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [CW-1:0]   code;
  logic            code_valid;
  logic            code_ready;
  logic            key_out;
  logic            busy;
  logic            code_error;
  logic [7*ND-1:0] hex;

  morse_player #(.UNIT_CYCLES(U), .NUM_DIGITS(ND), .CODE_WIDTH(CW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .key_out    (key_out),
    .busy       (busy),
    .code_error (code_error),
    .hex        (hex)
  );

  always #5 clock = ~clock;

  string mtab [36] = '{
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----.",
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---", "-.-", ".-..",
    "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
    "-.--", "--.."
  };

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: expected display digits and per-cycle key trace.
  logic [6:0] disp [ND];
  bit         key_q [$];
  int         start_q [$];
  logic [6:0] glyph_q [$];
  int         kind;

  function automatic logic [7*ND-1:0] disp_bus();
    logic [7*ND-1:0] r;
    for (int k = 0; k < ND; k++) r[7*k +: 7] = disp[k];
    return r;
  endfunction

  task automatic build(input int c);
    string s;
    int    dur;
    key_q.delete(); start_q.delete(); glyph_q.delete();
    if (c <= 35) begin
      kind = 0;
      s = mtab[c];
      for (int i = 0; i < s.len(); i++) begin
        dur = (s[i] == "-") ? 3 * U : U;
        for (int j = 0; j < dur; j++) begin
          key_q.push_back(1'b1);
          start_q.push_back(j == 0 ? i : -1);
          glyph_q.push_back((s[i] == "-") ? G_DASH : G_DOT);
        end
        dur = (i == s.len() - 1) ? 3 * U : U;
        for (int j = 0; j < dur; j++) begin
          key_q.push_back(1'b0);
          start_q.push_back(-1);
          glyph_q.push_back(G_OFF);
        end
      end
    end else if (c == 36) begin
      kind = 1;
      for (int j = 0; j < 7 * U; j++) begin
        key_q.push_back(1'b0); start_q.push_back(-1); glyph_q.push_back(G_OFF);
      end
    end else begin
      kind = 2;
      key_q.push_back(1'b0); start_q.push_back(-1); glyph_q.push_back(G_OFF);
    end
  endtask

  // Starts at a falling edge with the DUT idle; returns at the falling edge of
  // the first idle cycle after playback (or right after an injected reset).
  task automatic play(input int c, input bit hold, input int nc, input int abort_at);
    check("idle_ready", code_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_key", key_out, 0);
    check("idle_hex", hex, disp_bus());
    code = CW'(c);
    code_valid = 1'b1;
    build(c);
    for (int i = 0; i < key_q.size(); i++) begin
      @(negedge clock);
      if (i == 0) begin
        code_valid = hold;
        code = CW'(nc);
        for (int k = 0; k < ND; k++) disp[k] = G_OFF;
        if (kind == 2) begin
          disp[ND-1] = G_E; disp[ND-2] = G_R; disp[ND-3] = G_R;
          disp[ND-4] = G_DOT; disp[ND-5] = G_R;
        end
      end
      if (start_q[i] >= 0) disp[ND-1-start_q[i]] = glyph_q[i];
      check("key", key_out, key_q[i]);
      check("busy", busy, 1);
      check("ready_busy", code_ready, 0);
      check("code_error", code_error, (kind == 2 && i == 0) ? 1 : 0);
      check("hex", hex, disp_bus());
      if (abort_at == i + 1) begin
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < ND; k++) disp[k] = G_OFF;
        check("rst_key", key_out, 0);
        check("rst_hex", hex, disp_bus());
        check("rst_ready", code_ready, 1);
        check("rst_busy", busy, 0);
        return;
      end
    end
    @(negedge clock);
    check("end_error", code_error, 0);
  endtask

  int cur, nxt;
  bit h;

  initial begin
    reset_n = 1'b0;
    code_valid = 1'b0;
    code = '0;
    for (int k = 0; k < ND; k++) disp[k] = G_OFF;
    repeat (3) @(negedge clock);
    check("reset_ready", code_ready, 1);
    check("reset_key", key_out, 0);
    check("reset_busy", busy, 0);
    check("reset_error", code_error, 0);
    check("reset_hex", hex, disp_bus());
    reset_n = 1'b1;
    @(negedge clock);

    // Directed: E, A, 0, word space, invalid code.
    play(14, 0, 0, 0);
    play(10, 0, 0, 0);
    play(0, 0, 0, 0);
    play(36, 0, 0, 0);
    play(40, 0, 0, 0);
    play(63, 0, 0, 0);

    // Code held during playback is taken only once idle, then played at once.
    play(17, 1, 22, 0);
    play(22, 0, 0, 0);

    // Reset in the third mark of code 0.
    play(0, 0, 0, 38);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("post_rst_key", key_out, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_hex", hex, disp_bus());
    end

    // Randomised sequence, with occasional back-to-back held codes.
    cur = $urandom_range(0, 63);
    for (int n = 0; n < 40; n++) begin
      nxt = $urandom_range(0, 63);
      h = ($urandom_range(0, 1) == 1);
      play(cur, h, h ? nxt : 0, 0);
      if (h) cur = nxt;
      else begin
        cur = $urandom_range(0, 63);
        repeat ($urandom_range(0, 3)) @(negedge clock);
      end
    end
    play(cur, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
